// File: rtl/inertial_filter_module.sv
// inertial_filter_module: synchronizes a raw level and accepts a change only after it holds for MIN_CYCLES samples
`timescale 1ns/1ps
module inertial_filter_module #(
    parameter int MIN_CYCLES = 4,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din,
    input  logic              drop_clr,
    output logic              so_filt,
    output logic              so_rise,
    output logic              so_fall,
    output logic              pend,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int            CW       = $clog2(MIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MIN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {ST_LO, PEND_HI, ST_HI, PEND_LO} state_t;

    logic              sync1_q, din_s_q;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rise_q, rise_d, fall_q, fall_d, drop;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // two-flop synchronizer; only din_s_q feeds the qualifier
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
        end
    end

    // qualifier: a candidate level must be seen MIN_CYCLES times in a row, any reversion is a dropped glitch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_LO: if (din_s_q) begin
                state_d = PEND_HI;
                cnt_d   = CNT_ONE;
            end
            PEND_HI: if (!din_s_q) begin
                state_d = ST_LO;
                cnt_d   = '0;
                drop    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_HI;
                cnt_d   = '0;
                rise_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_HI: if (!din_s_q) begin
                state_d = PEND_LO;
                cnt_d   = CNT_ONE;
            end
            PEND_LO: if (din_s_q) begin
                state_d = ST_HI;
                cnt_d   = '0;
                drop    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_LO;
                cnt_d   = '0;
                fall_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // clear has priority over a simultaneous drop; the count sticks at all-ones
    always_comb begin
        drop_cnt_d = drop_clr ? '0 : (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    // qualifier state, edge pulses and glitch counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_LO;
            cnt_q      <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign so_filt  = (state_q == ST_HI) || (state_q == PEND_LO);
    assign pend     = (state_q == PEND_HI) || (state_q == PEND_LO);
    assign so_rise  = rise_q;
    assign so_fall  = fall_q;
    assign drop_cnt = drop_cnt_q;
endmodule
